// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator family.
// Holds the control FSM state encoding and the default datapath widths.
package mac_pkg;

   // Control FSM states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } mac_state_e;

   // Default datapath widths
   localparam int unsigned PROD_W_DEF = 32;
   localparam int unsigned ACC_W_DEF  = 40;
   localparam int unsigned LEN_W_DEF  = 8;

endpackage : mac_pkg

// File: rtl/mac_sat_adder.sv
// Combinational saturating accumulator adder.
// Adds an unsigned PROD_W addend to an ACC_W accumulator in ACC_W+1 bits.
// A carry out of ACC_W bits, or an already-set overflow, pins the result
// to all ones and raises ovf_out.
// Ports:
//   acc_in   in  ACC_W   current accumulator value
//   addend   in  PROD_W  unsigned value to add
//   ovf_in   in  1       overflow already seen earlier in the job
//   sum_out  out ACC_W   saturated sum
//   ovf_out  out 1       overflow seen up to and including this addition
module mac_sat_adder #(
   parameter int unsigned PROD_W = 32,
   parameter int unsigned ACC_W  = 40
) (
   input  logic [ACC_W-1:0]  acc_in,
   input  logic [PROD_W-1:0] addend,
   input  logic              ovf_in,
   output logic [ACC_W-1:0]  sum_out,
   output logic              ovf_out
);

   localparam int unsigned EXT_W = ACC_W + 1;

   logic [EXT_W-1:0] sum_ext;

   // One spare bit catches the carry out of the accumulator width
   always_comb begin
      sum_ext = {1'b0, acc_in} + EXT_W'(addend);
      ovf_out = sum_ext[ACC_W] | ovf_in;
      sum_out = ovf_out ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
   end

endmodule : mac_sat_adder

// File: rtl/mac_accumulator.sv
// Sequential MAC accumulation stage.
// Sums a programmed number of unsigned products received over a
// valid/ready stream and presents the saturated sum with a sticky
// overflow flag on a registered valid/ready result port.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start,length  job request and beat count (sampled in IDLE only)
//   flush         synchronous abort back to IDLE, highest priority
//   in_valid/in_ready/in_prod       product input stream
//   out_valid/out_ready/out_sum/out_overflow  result handshake
//   busy          high whenever the block is not IDLE
module mac_accumulator
   import mac_pkg::*;
#(
   parameter int unsigned PROD_W = PROD_W_DEF,
   parameter int unsigned ACC_W  = ACC_W_DEF,
   parameter int unsigned LEN_W  = LEN_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  length,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic              out_overflow,
   output logic              busy
);

   mac_state_e       state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             ovf_q, ovf_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;

   logic             beat;
   logic [ACC_W-1:0] add_sum;
   logic             add_ovf;

   // Saturating adder for one accepted beat
   mac_sat_adder #(
      .PROD_W (PROD_W),
      .ACC_W  (ACC_W)
   ) u_sat_adder (
      .acc_in  (acc_q),
      .addend  (in_prod),
      .ovf_in  (ovf_q),
      .sum_out (add_sum),
      .ovf_out (add_ovf)
   );

   // Ready for the whole ACCUM state, suppressed while flushing
   assign in_ready = (state_q == ACCUM) && !flush;
   assign beat     = in_valid && in_ready;

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      ovf_d   = ovf_q;
      rem_d   = rem_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               acc_d = '0;
               ovf_d = 1'b0;
               if (length != '0) begin
                  rem_d   = length;
                  state_d = ACCUM;
               end else begin
                  state_d = HOLD;
               end
            end
         end
         ACCUM: begin
            if (beat) begin
               acc_d = add_sum;
               ovf_d = add_ovf;
               rem_d = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort wins over start and every handshake in the same cycle
      if (flush) begin
         state_d = IDLE;
         acc_d   = '0;
         ovf_d   = 1'b0;
         rem_d   = '0;
      end

      // Status outputs registered from the next state
      out_valid_d = (state_d == HOLD);
      busy_d      = (state_d != IDLE);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         rem_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         rem_q       <= rem_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_sum      = acc_q;
   assign out_overflow = ovf_q;
   assign busy         = busy_q;

endmodule : mac_accumulator

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: a 33-bit accumulator instance
// (exercises saturation) and a default 40-bit instance share one stimulus
// stream; each has its own expected-result queue and monitor.
module tb_mac_accumulator;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  length;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_prod;
   logic        out_ready;

   logic        in_ready_a, out_valid_a, out_overflow_a, busy_a;
   logic [32:0] out_sum_a;
   logic        in_ready_b, out_valid_b, out_overflow_b, busy_b;
   logic [39:0] out_sum_b;

   typedef struct {
      logic [39:0] sum;
      logic        ovf;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];

   int n_checks = 0;
   int n_fail   = 0;

   mac_accumulator #(.PROD_W(32), .ACC_W(33), .LEN_W(8)) u_dut33 (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .length       (length),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready_a),
      .in_prod      (in_prod),
      .out_valid    (out_valid_a),
      .out_ready    (out_ready),
      .out_sum      (out_sum_a),
      .out_overflow (out_overflow_a),
      .busy         (busy_a)
   );

   mac_accumulator u_dut40 (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .length       (length),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready_b),
      .in_prod      (in_prod),
      .out_valid    (out_valid_b),
      .out_ready    (out_ready),
      .out_sum      (out_sum_b),
      .out_overflow (out_overflow_b),
      .busy         (busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [39:0] s33, input logic o33,
                           input logic [39:0] s40, input logic o40);
      exp_t e;
      e.sum = s33; e.ovf = o33; q_a.push_back(e);
      e.sum = s40; e.ovf = o40; q_b.push_back(e);
   endtask

   task automatic start_job(input logic [7:0] len);
      start  = 1'b1;
      length = len;
      tick();
      start  = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] p);
      int guard;
      in_valid = 1'b1;
      in_prod  = p;
      guard    = 0;
      while (!(in_ready_a && in_ready_b) && guard < 20) begin
         tick();
         guard++;
      end
      if (guard >= 20) check("beat_ready_timeout", 64'(in_ready_a), 64'd1);
      tick();
   endtask

   task automatic wait_idle();
      int guard;
      guard = 0;
      while ((busy_a || busy_b) && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50) check("idle_timeout", 64'(busy_a), 64'd0);
   endtask

   task automatic check_both(input string name, input logic a, input logic b, input logic exp);
      check({name, "_a33"}, 64'(a), 64'(exp));
      check({name, "_b40"}, 64'(b), 64'(exp));
   endtask

   // Monitor for the 33-bit instance: compare head entry every valid cycle
   always @(negedge clk) begin
      if (rst_n && out_valid_a) begin
         if (q_a.size() == 0) begin
            check("unexpected_out_a33", 64'(out_sum_a), 64'h0);
            check("unexpected_valid_a33", 64'(out_valid_a), 64'd0);
         end else begin
            check("sum_a33", 64'(out_sum_a), 64'(q_a[0].sum));
            check("ovf_a33", 64'(out_overflow_a), 64'(q_a[0].ovf));
            if (out_ready) void'(q_a.pop_front());
         end
      end
   end

   // Monitor for the 40-bit instance
   always @(negedge clk) begin
      if (rst_n && out_valid_b) begin
         if (q_b.size() == 0) begin
            check("unexpected_valid_b40", 64'(out_valid_b), 64'd0);
         end else begin
            check("sum_b40", 64'(out_sum_b), 64'(q_b[0].sum));
            check("ovf_b40", 64'(out_overflow_b), 64'(q_b[0].ovf));
            if (out_ready) void'(q_b.pop_front());
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      length    = '0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_prod   = '0;
      out_ready = 1'b1;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check_both("rst_out_valid", out_valid_a, out_valid_b, 1'b0);
      check_both("rst_busy", busy_a, busy_b, 1'b0);
      check_both("rst_in_ready", in_ready_a, in_ready_b, 1'b0);
      check_both("rst_ovf", out_overflow_a, out_overflow_b, 1'b0);
      check("rst_sum_a33", 64'(out_sum_a), 64'd0);
      check("rst_sum_b40", 64'(out_sum_b), 64'd0);
      rst_n = 1'b1;
      tick();

      // Basic job: 6+7+8
      push_exp(40'd21, 1'b0, 40'd21, 1'b0);
      start_job(8'd3);
      send_beat(32'd6);
      send_beat(32'd7);
      send_beat(32'd8);
      in_valid = 1'b0;
      check_both("t1_latency_valid", out_valid_a, out_valid_b, 1'b1);
      wait_idle();

      // Backpressure with a gap between beats
      out_ready = 1'b0;
      push_exp(40'h1_FFFC_0002, 1'b0, 40'h1_FFFC_0002, 1'b0);
      start_job(8'd2);
      send_beat(32'hFFFE_0001);
      in_valid = 1'b0;
      tick();
      send_beat(32'hFFFE_0001);
      in_valid = 1'b0;
      check_both("t2_valid_rise", out_valid_a, out_valid_b, 1'b1);
      repeat (4) tick();
      check_both("t2_valid_held", out_valid_a, out_valid_b, 1'b1);
      out_ready = 1'b1;
      tick();
      check_both("t2_valid_drop", out_valid_a, out_valid_b, 1'b0);
      wait_idle();

      // Saturation in 33 bits; 40 bits holds the true sum
      push_exp(40'h1_FFFF_FFFF, 1'b1, 40'h2_FFFF_FFFD, 1'b0);
      start_job(8'd3);
      repeat (3) send_beat(32'hFFFF_FFFF);
      in_valid = 1'b0;
      wait_idle();

      // Sticky overflow: a trailing zero beat must not clear it
      push_exp(40'h1_FFFF_FFFF, 1'b1, 40'h2_FFFF_FFFD, 1'b0);
      start_job(8'd4);
      repeat (3) send_beat(32'hFFFF_FFFF);
      send_beat(32'd0);
      in_valid = 1'b0;
      wait_idle();

      // Fresh job after overflow
      push_exp(40'd5, 1'b0, 40'd5, 1'b0);
      start_job(8'd1);
      send_beat(32'd5);
      in_valid = 1'b0;
      wait_idle();

      // Zero length job
      push_exp(40'd0, 1'b0, 40'd0, 1'b0);
      start_job(8'd0);
      check_both("t4_zero_valid", out_valid_a, out_valid_b, 1'b1);
      check_both("t4_zero_in_ready", in_ready_a, in_ready_b, 1'b0);
      wait_idle();

      // Flush after 2 of 5 beats; beat offered during flush is refused
      start_job(8'd5);
      send_beat(32'd10);
      send_beat(32'd20);
      flush    = 1'b1;
      in_valid = 1'b1;
      in_prod  = 32'd100;
      #1;
      check_both("t5_flush_in_ready", in_ready_a, in_ready_b, 1'b0);
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      check_both("t5_flush_busy", busy_a, busy_b, 1'b0);
      check_both("t5_flush_valid", out_valid_a, out_valid_b, 1'b0);
      push_exp(40'd9, 1'b0, 40'd9, 1'b0);
      start_job(8'd1);
      send_beat(32'd9);
      in_valid = 1'b0;
      wait_idle();

      // Reset mid-ACCUM
      start_job(8'd4);
      send_beat(32'd3);
      send_beat(32'd4);
      rst_n = 1'b0;
      #1;
      check_both("t6_rst_busy", busy_a, busy_b, 1'b0);
      check_both("t6_rst_in_ready", in_ready_a, in_ready_b, 1'b0);
      check_both("t6_rst_valid", out_valid_a, out_valid_b, 1'b0);
      check("t6_rst_sum_a33", 64'(out_sum_a), 64'd0);
      check("t6_rst_sum_b40", 64'(out_sum_b), 64'd0);
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // Start during ACCUM is ignored; original count of 4 honoured
      push_exp(40'd10, 1'b0, 40'd10, 1'b0);
      start_job(8'd4);
      send_beat(32'd1);
      start  = 1'b1;
      length = 8'd7;
      send_beat(32'd2);
      start  = 1'b0;
      send_beat(32'd3);
      send_beat(32'd4);
      in_valid = 1'b0;
      check_both("t7_valid_after_4", out_valid_a, out_valid_b, 1'b1);
      wait_idle();
      repeat (10) tick();

      check("pending_a33", 64'(q_a.size()), 64'd0);
      check("pending_b40", 64'(q_b.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mac_accumulator

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Sequential accumulation stage directly downstream of the 16x16 unsigned multiplier.
- Consumes a stream of 32-bit products over a valid/ready handshake and sums a programmed number of them into a wide accumulator.
- Presents the sum, with a sticky overflow flag, on a registered valid/ready output.
- Turns the combinational multiplier into a dot-product / MAC datapath.

Parameters:
- PROD_W, 32, width of each incoming product (unsigned).
- ACC_W, 40, accumulator and result width; must be >= PROD_W.
- LEN_W, 8, width of the beat-count field; up to 2^LEN_W-1 products per job.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle job request; sampled only in IDLE.
- length  in  LEN_W  number of products in the job; sampled with start.
- flush  in  1  synchronous abort; returns the block to IDLE from any state.
- in_valid  in  1  product beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_prod  in  PROD_W  unsigned product value.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACC_W  accumulated sum, saturated.
- out_overflow  out  1  set if any addition in the job exceeded ACC_W bits.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (rst_n); all flops clear on rst_n low.
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_sum=0, out_overflow=0, busy=0, remaining count=0.
- FSM states: IDLE, ACCUM, HOLD.
- IDLE, start=1 and length!=0:
  - accumulator <= 0, overflow <= 0, remaining <= length.
  - Next state ACCUM.
- IDLE, start=1 and length==0:
  - accumulator <= 0, overflow <= 0.
  - Next state HOLD, so out_valid=1 with sum 0 in the next cycle.
- IDLE, start=0: stay in IDLE.
- ACCUM:
  - in_ready=1 combinationally (asserted for the whole state).
  - A beat transfers on in_valid & in_ready.
  - Per beat: sum_ext = {1'b0, acc} + in_prod zero-extended to ACC_W+1 bits.
  - If sum_ext[ACC_W]=1 or overflow is already set: acc <= all ones and overflow <= 1.
  - Otherwise acc <= sum_ext[ACC_W-1:0].
  - remaining decrements by one per beat.
  - The beat that brings remaining to 0 moves the FSM to HOLD.
  - Idle cycles (in_valid=0) hold all state.
- HOLD:
  - out_valid=1; out_sum and out_overflow are driven from registers and stay stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: next state IDLE, out_valid falls the following cycle.
  - in_ready=0.
- Latency: out_valid rises on the clock edge after the last accepted beat (1 cycle); throughput is 1 beat/cycle in ACCUM.
- start outside IDLE is ignored; length is not resampled.
- start in the same cycle as the HOLD->IDLE handshake is ignored; a new job needs start in a cycle where state==IDLE.
- flush:
  - Highest priority over start and over every handshake in the same cycle.
  - Next state IDLE; out_valid=0 next cycle; accumulator and overflow cleared; any beat presented that cycle is not accepted (in_ready forced 0 while flush=1).
- Reset mid-job: immediate return to reset values; no partial result is emitted.
- out_sum is readable only while out_valid=1; its value outside HOLD is don't-care for checking, but it is cleared by reset and flush.

Decomposition:
- Shared package mac_pkg holds:
  - the state enum (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2);
  - default widths PROD_W_DEF=32, ACC_W_DEF=40, LEN_W_DEF=8.
- One natural sub-module: mac_sat_adder, a combinational ACC_W+1 adder with saturation and overflow output, reused by later signed variants.
- FSM, counter and output register stay in the top module.

Test Plan:
- Basic job: start, length=3; products 0x0000_0006, 0x0000_0007, 0x0000_0008 with in_valid held high -> out_valid exactly 1 cycle after the 3rd beat, out_sum=21, out_overflow=0.
- Backpressure and gaps:
  - length=2, beats 0xFFFE_0001 (65535*65535) twice, with an idle cycle between them and out_ready held low for 4 cycles.
  - Required: out_sum=0x1_FFFC_0002, stable while waiting; out_valid drops the cycle after out_ready=1.
- Saturation:
  - ACC_W=33, length=3, three beats of 0xFFFF_FFFF -> out_sum=0x1_FFFF_FFFF, out_overflow=1.
  - Then a new job of length=1 with product 5 -> out_sum=5, out_overflow=0.
- Zero length: start, length=0 -> out_valid next cycle, out_sum=0, and in_ready never asserted.
- Flush and reset:
  - flush asserted after 2 of 5 beats -> busy=0 next cycle, no out_valid; next job of length=1 with product 9 yields 9.
  - rst_n pulsed low mid-ACCUM -> all outputs at reset values asynchronously.
- Ignored start: start pulsed during ACCUM with length=7 -> the original count of 4 is honoured, and exactly one result is produced.
